// File: rtl/lifo_req_arbiter.sv
// Round-robin arbiter serialising N_REQ push/pop requesters onto one shared LIFO stack.
// Latency: push or error response 1 cycle after grant, successful pop response 2 cycles after grant.
// Backpressure: req_ready grants at most one requester per cycle and none during POP_WAIT; responses cannot be stalled.
module lifo_req_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int ID_W  = 2,
    parameter int LVL_W = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_op,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_err,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [LVL_W-1:0]       level,
    output logic                   busy,
    output logic                   lifo_push,
    output logic                   lifo_pop,
    output logic [WIDTH-1:0]       lifo_din,
    input  logic [WIDTH-1:0]       lifo_dout,
    input  logic                   lifo_full,
    input  logic                   lifo_empty
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_POP_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  r_pop_id;
    logic [LVL_W-1:0] r_level;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic             r_rsp_err;
    logic [WIDTH-1:0] r_rsp_data;

    logic [ID_W:0]    w_idx;
    logic             w_found;
    logic [ID_W-1:0]  w_win;
    logic             w_grant;
    logic             w_sel_op;
    logic [WIDTH-1:0] w_sel_data;

    // Winner search: first valid requester starting at the round-robin pointer, wrapping modulo N_REQ.
    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
            if (w_idx >= (ID_W+1)'(N_REQ)) begin
                w_idx = w_idx - (ID_W+1)'(N_REQ);
            end
            if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[ID_W-1:0];
            end
        end
    end

    // Grants are only issued out of reset and while idle; POP_WAIT is the cycle the stack read data lands.
    assign w_grant    = rstn && (r_state == ST_IDLE) && w_found;
    assign w_sel_op   = req_op[w_win];
    assign w_sel_data = req_data[int'(w_win)*WIDTH +: WIDTH];

    // Next-state logic plus grant and stack strobes; errors consume the grant but never strobe the stack.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        lifo_push   = 1'b0;
        lifo_pop    = 1'b0;
        lifo_din    = '0;
        if (w_grant) begin
            req_ready[w_win] = 1'b1;
            if (!w_sel_op) begin
                if (!lifo_full) begin
                    lifo_push = 1'b1;
                    lifo_din  = w_sel_data;
                end
            end else if (!lifo_empty) begin
                lifo_pop    = 1'b1;
                w_state_nxt = ST_POP_WAIT;
            end
        end else if (r_state == ST_POP_WAIT) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Round-robin pointer, occupancy tracking and the registered response pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rr_ptr    <= '0;
            r_pop_id    <= '0;
            r_level     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_grant) begin
                r_rr_ptr <= (w_win == ID_W'(N_REQ-1)) ? '0 : w_win + ID_W'(1);
                if (!w_sel_op) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= w_win;
                    r_rsp_err   <= lifo_full;
                    r_rsp_data  <= '0;
                    if (!lifo_full) begin
                        r_level <= r_level + LVL_W'(1);
                    end
                end else if (lifo_empty) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= w_win;
                    r_rsp_err   <= 1'b1;
                    r_rsp_data  <= '0;
                end else begin
                    r_level  <= r_level - LVL_W'(1);
                    r_pop_id <= w_win;
                end
            end else if (r_state == ST_POP_WAIT) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_pop_id;
                r_rsp_err   <= 1'b0;
                r_rsp_data  <= lifo_dout;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_data;
    assign level     = r_level;
    assign busy      = (r_state == ST_POP_WAIT);

endmodule

// File: doc/lifo_req_arbiter.md
Name: lifo_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares one LIFO stack block among N_REQ requesters. Each requester issues push or pop transactions through a valid/ready handshake. The arbiter serialises them onto the stack's push/pop/din port, checks the full/empty flags, and returns a tagged single-cycle response carrying the pop data or an error. It sits between client logic and the stack instance; both blocks share clk and rstn.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, data width; must equal the stack's WIDTH
DEPTH, 8, stack capacity; must equal the stack's DEPTH
ID_W, 2, requester-id width, >= clog2(N_REQ)
LVL_W, 4, occupancy width, >= clog2(DEPTH+1)

Ports:
clk  input  1  clock, rising edge
rstn  input  1  reset, synchronous, active-low
req_valid  input  N_REQ  per-requester transaction request
req_op  input  N_REQ  per-requester op: 0=push, 1=pop
req_data  input  N_REQ*WIDTH  push data; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  output  N_REQ  grant/accept, one-hot or zero, combinational
rsp_valid  output  1  response pulse, registered
rsp_id  output  ID_W  index of the requester being answered
rsp_err  output  1  1 = push to full stack or pop from empty stack
rsp_data  output  WIDTH  pop data; 0 for pushes and errors
level  output  LVL_W  stack occupancy tracked by the arbiter
busy  output  1  1 while in POP_WAIT
lifo_push  output  1  stack push strobe, combinational
lifo_pop  output  1  stack pop strobe, combinational
lifo_din  output  WIDTH  stack write data
lifo_dout  input  WIDTH  stack registered read data, valid the cycle after a pop strobe
lifo_full  input  1  stack full flag
lifo_empty  input  1  stack empty flag

Behaviour:
- Reset (rstn=0 at a clk edge): state<=IDLE, rr_ptr<=0, level<=0, rsp_valid/rsp_err<=0, rsp_id<=0, rsp_data<=0. Strobes and req_ready are 0 while rstn=0. The stack is reset by the same rstn.
- FSM has two states: IDLE and POP_WAIT.
- IDLE, any req_valid set:
  - Winner w = first set req_valid scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - Same cycle: req_ready[w]=1. At the edge, rr_ptr<=(w+1) mod N_REQ.
- Push accepted, lifo_full=0: lifo_push=1, lifo_din=req_data[w]. Next edge: rsp_valid=1, rsp_id=w, rsp_err=0, rsp_data=0, level+1. State stays IDLE, so back-to-back pushes run at 1 per cycle.
- Push accepted, lifo_full=1: no strobe. Next edge: rsp_valid=1, rsp_err=1, rsp_data=0. level unchanged.
- Pop accepted, lifo_empty=0: lifo_pop=1, level-1 at the edge, state->POP_WAIT, latched id<=w.
- POP_WAIT (exactly 1 cycle):
  - req_ready=0 and no strobes.
  - At the edge: rsp_valid=1, rsp_id=latched id, rsp_data=lifo_dout, rsp_err=0; state->IDLE.
  - Pop latency: 2 cycles from acceptance to rsp_valid.
- Pop accepted, lifo_empty=1: no strobe. Next edge: rsp_valid=1, rsp_err=1, rsp_data=0 (1-cycle latency).
- Strobes: lifo_push and lifo_pop are never asserted together. lifo_din=0 when lifo_push=0.
- Responses: rsp_valid is a one-cycle pulse with no backpressure; otherwise rsp_valid=0 and the other rsp_* fields hold their last value.
- Requester side: a requester holds req_valid/req_op/req_data stable until it sees req_ready. Dropping req_valid before grant withdraws the request.
- Rejected (error) transactions still consume their grant and advance rr_ptr.
- level saturates by construction (0..DEPTH) and must always match stack occupancy. A mismatch with the flags (level==DEPTH xor lifo_full, or level==0 xor lifo_empty) is a bench assertion.
- Reset asserted in POP_WAIT: no response is issued, state->IDLE, level=0.
- No req_valid set: no grant, rr_ptr holds.

Test Plan:
1. Reset with all req_valid=1 held → req_ready=0, strobes=0, rsp_valid=0, level=0 throughout reset. First grant after release goes to requester 0.
2. Requester 0 pushes 0x11,0x22,0x33 on consecutive cycles → req_ready[0] high 3 cycles, 3 rsp_valid pulses (err=0), level=3. Three pops → rsp_data 0x33,0x22,0x11, each 2 cycles after grant, no grant in POP_WAIT, level=0.
3. All 4 requesters push simultaneously (data 0xA0..0xA3) from rr_ptr=0 → grants 0,1,2,3 on consecutive cycles, rsp_id 0..3, rr_ptr back to 0, level=4.
4. Push 8 values, then a 9th push → rsp_err=1, lifo_push not asserted, level stays 8, lifo_full=1. Pop 8, then a 9th pop → rsp_err=1, rsp_data=0, lifo_pop not asserted, response 1 cycle after grant.
5. rr_ptr=2; requester 1 pushes 0x5A while requester 2 pops with the stack holding [0x07] → requester 2 granted first, rsp_data=0x07. Requester 1 is granted after POP_WAIT, then level=1.
6. rstn pulled low during POP_WAIT → no rsp_valid, state IDLE, level=0, rr_ptr=0. A subsequent pop → rsp_err=1.
